// File: rtl/mc_pkg.sv
// Shared ISA constants, FSM state encoding, ALU op encoding and helpers
// for the multi-cycle MIPS-subset core.
package mc_pkg;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_WB_I,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_NOR,
      ALU_SLT
   } alu_op_t;

   function automatic logic [31:0] sign_ext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x 32 register file: two asynchronous read ports, one synchronous
// write port; register 0 always reads zero and never stores anything.
module mc_regfile #(
   parameter int NREG = 32,
   parameter int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic [RW-1:0] raddr_a,
   input  logic [RW-1:0] raddr_b,
   output logic [31:0]   rdata_a,
   output logic [31:0]   rdata_b,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [31:0]   wdata
);

   logic [31:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_core_param.sv
// Parametrised multi-cycle MIPS-subset core on a single ready-handshaked
// instruction/data memory port.
module mc_core_param
   import mc_pkg::*;
#(
   parameter int            AW       = 16,
   parameter int            NREG     = 32,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ready,
   output logic          halted,
   output logic          illegal
);

   localparam int RW = $clog2(NREG);

   state_t        state_reg, state_next;
   logic [AW-1:0] pc_reg;
   logic [31:0]   ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
   logic          illegal_reg;

   logic [5:0]    opcode, funct;
   logic [RW-1:0] rs_idx, rt_idx, rd_idx, rf_waddr;
   logic [31:0]   imm_ext, rs_data, rt_data, alu_result, wb_data;
   logic [AW-1:0] branch_target, jump_target;
   alu_op_t       alu_op;
   logic          funct_ok, op_illegal, rf_we, branch_taken;

   assign opcode        = ir_reg[31:26];
   assign funct         = ir_reg[5:0];
   assign rs_idx        = ir_reg[21 +: RW];
   assign rt_idx        = ir_reg[16 +: RW];
   assign rd_idx        = ir_reg[11 +: RW];
   assign imm_ext       = sign_ext(ir_reg[15:0]);
   // pc_reg already points past the branch when DECODE computes the target
   assign branch_target = pc_reg + imm_ext[AW-1:0];
   assign jump_target   = AW'(ir_reg[25:0]);
   assign branch_taken  = (a_reg == b_reg) ^ (opcode == OP_BNE);

   assign halted  = (state_reg == S_HALT);
   assign illegal = illegal_reg;

   always_comb begin
      alu_op   = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_SLT:  alu_op = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD: alu_result = a_reg + b_reg;
         ALU_SUB: alu_result = a_reg - b_reg;
         ALU_AND: alu_result = a_reg & b_reg;
         ALU_OR:  alu_result = a_reg | b_reg;
         ALU_NOR: alu_result = ~(a_reg | b_reg);
         ALU_SLT: alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
         default: alu_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = alu_out_reg[AW-1:0];
      mem_wdata  = '0;
      rf_we      = 1'b0;
      rf_waddr   = rt_idx;
      wb_data    = alu_out_reg;
      op_illegal = 1'b0;
      case (state_reg)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_reg;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_R:                  state_next = S_EXEC_R;
               OP_LW, OP_SW, OP_ADDI: state_next = S_ADDR;
               OP_BEQ, OP_BNE:        state_next = S_BRANCH;
               OP_J:                  state_next = S_JUMP;
               OP_HALT:               state_next = S_HALT;
               default: begin
                  op_illegal = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: state_next = funct_ok ? S_WB_R : S_FETCH;
         S_WB_R: begin
            rf_we      = 1'b1;
            rf_waddr   = rd_idx;
            state_next = S_FETCH;
         end
         S_ADDR: begin
            case (opcode)
               OP_LW:   state_next = S_MEM_RD;
               OP_SW:   state_next = S_MEM_WR;
               default: state_next = S_WB_I;
            endcase
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ready) state_next = S_WB_MEM;
         end
         S_WB_MEM: begin
            rf_we      = 1'b1;
            wb_data    = mdr_reg;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = b_reg;
            if (mem_ready) state_next = S_FETCH;
         end
         S_WB_I: begin
            rf_we      = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: state_next = S_FETCH;
         S_JUMP:   state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg      <= RESET_PC;
         ir_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         alu_out_reg <= '0;
         mdr_reg     <= '0;
         illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_reg <= mem_rdata;
                  pc_reg <= pc_reg + AW'(1);
               end
            end
            S_DECODE: begin
               a_reg       <= rs_data;
               b_reg       <= rt_data;
               alu_out_reg <= 32'(branch_target);
               if (op_illegal) illegal_reg <= 1'b1;
            end
            S_EXEC_R: begin
               if (funct_ok) alu_out_reg <= alu_result;
               else          illegal_reg <= 1'b1;
            end
            S_ADDR:   alu_out_reg <= a_reg + imm_ext;
            S_MEM_RD: if (mem_ready) mdr_reg <= mem_rdata;
            S_BRANCH: if (branch_taken) pc_reg <= alu_out_reg[AW-1:0];
            S_JUMP:   pc_reg <= jump_target;
            default:  ;
         endcase
      end
   end

   // A write-back state caught by reset must not touch the register file
   mc_regfile #(
      .NREG (NREG),
      .RW   (RW)
   ) u_regfile (
      .clk     (clk),
      .raddr_a (rs_idx),
      .raddr_b (rt_idx),
      .rdata_a (rs_data),
      .rdata_b (rt_data),
      .we      (rf_we & ~rst),
      .waddr   (rf_waddr),
      .wdata   (wb_data)
   );

endmodule

// File: doc/mc_core_param.md
Name: mc_core_param

Overview:
- Parametrised next-generation multi-cycle CPU core.
- Executes a MIPS-subset ISA over one shared instruction/data memory port.
- Differences from the current fixed core:
  - synchronous reset;
  - ready-handshaked external memory, so wait states are tolerated;
  - configurable address width, register count and reset PC;
  - adds bne, halt and illegal-opcode detection.
- Top-level CPU instance in the system; memory and peripherals live outside it.

Parameters:
- AW, 16: word-address width of mem_addr and PC (8..30).
- NREG, 32: register-file entries; power of 2, 2..32. Register index is the low log2(NREG) bits of each 5-bit instruction field.
- RESET_PC, 0: PC value after reset (AW bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the current transaction.
- halted  out  1  core is in HALT.
- illegal  out  1  sticky flag: unknown opcode or funct seen.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - PC<=RESET_PC; state<=FETCH; illegal<=0.
  - IR, A, B, ALUOut, MDR<=0. Register contents are unchanged.
  - Outputs after reset: mem_req=1 (FETCH), mem_we=0, mem_addr=RESET_PC, mem_wdata=0, halted=0.
  - Reset during a pending transaction drops it; no completion is recorded.
- Memory handshake:
  - Core holds mem_req=1 with stable mem_addr/mem_we/mem_wdata until the edge where mem_ready=1. That edge completes the transaction.
  - mem_req falls for at least the next cycle unless the next state is also a memory state.
  - mem_ready while mem_req=0 is ignored.
  - Zero-wait memory (mem_ready tied to 1) is legal.
- Addressing:
  - Word addressed; PC increments by 1.
  - Load/store address = (A + signext(imm))[AW-1:0].
  - Branch target = PC+1 + signext(imm), truncated to AW.
  - Jump target = addr26[AW-1:0] (zero-extended if AW>26).
  - All PC arithmetic wraps modulo 2^AW.
- Register file: register 0 reads as zero and ignores writes. Writes occur in writeback states only.
- ALU:
  - 32-bit; add/sub wrap, no overflow trap.
  - slt is signed, result 1/0.
  - Ops: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
- Opcodes: R=0x00, lw=0x23, sw=0x2B, addi=0x08, beq=0x04, bne=0x05, j=0x02, halt=0x3F.
- State machine (minimum cycles with zero-wait memory):
  - FETCH: request PC. On ready: IR<=mem_rdata, PC<=PC+1, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=branch target. Dispatch by opcode:
    - R: go to EXEC_R.
    - lw/sw/addi: go to ADDR.
    - beq/bne: go to BRANCH.
    - j: go to JUMP.
    - halt: go to HALT.
    - other: illegal<=1, go to FETCH (executes as NOP).
  - EXEC_R: ALUOut<=A op B, go to WB_R. Unknown funct: illegal<=1, go to FETCH, no write.
  - WB_R: R[rd]<=ALUOut, go to FETCH.
  - ADDR: ALUOut<=A+signext(imm). Next state is MEM_RD for lw, MEM_WR for sw, WB_I for addi.
  - MEM_RD: read at ALUOut. On ready: MDR<=mem_rdata, go to WB_MEM.
  - WB_MEM: R[rt]<=MDR, go to FETCH.
  - MEM_WR: write B to ALUOut. On ready, go to FETCH.
  - WB_I: R[rt]<=ALUOut, go to FETCH.
  - BRANCH: if (A==B) xor bne, PC<=ALUOut. Go to FETCH.
  - JUMP: PC<=jump target, go to FETCH.
  - HALT: halted=1, mem_req=0. Leaves only via rst.
- Resulting CPI (zero-wait): R 4, lw 5, sw 4, addi 4, branch 3, j 3. Each memory wait cycle adds 1.

Decomposition:
- Package mc_pkg holds:
  - opcode and funct constants;
  - the state enum (FETCH..HALT);
  - ALU-op encoding;
  - the sign-extend function.
- One sub-module, mc_regfile (NREG x 32): 2 asynchronous read ports, 1 synchronous write port, register 0 hard-wired to zero. ALU and FSM stay in the top.

Test Plan:
- Reset and fetch:
  - Stimulus: RESET_PC=0x10; rst for 2 cycles, then release; zero-wait memory.
  - Required: first mem_addr=0x10 with mem_req=1; a second fetch at 0x11 appears 4 cycles after the first fetch when the first instruction is an R-type.
- Arithmetic and store:
  - Stimulus: addi r1,r0,5; addi r2,r0,-7; slt r3,r2,r1; sub r4,r1,r2; sw r4,3(r0).
  - Required: a write to address 3 with data 12; r3=1.
- Load with wait states:
  - Stimulus: lw r5,0(r0) with mem_ready delayed 3 cycles on both fetch and data access; memory word 0 = 0xDEADBEEF.
  - Required: r5=0xDEADBEEF; mem_addr and mem_req held stable for all wait cycles.
- Control flow and wrap:
  - Stimulus: beq taken with offset -1 (self-loop, checked for 2 iterations); bne not taken; j 0x0040.
  - Required: PC sequence matches each case. With AW=8, PC=0xFF increments to 0x00.
- Halt, illegal and mid-transaction reset:
  - Stimulus: opcode 0x3F; opcode 0x11 (illegal); rst asserted while a load waits for ready.
  - Required after 0x3F: halted=1 and mem_req=0 thereafter.
  - Required after 0x11: illegal=1 and execution continues at the next PC.
  - Required after the mid-load rst: fetch restarts at RESET_PC; the destination register is unchanged.
